// File: rtl/jtdsp16_ram.sv
// -----------------------------------------------------------------------------
// jtdsp16_ram
// Data RAM stage fed by the YAAU pointer. Performs reads, writes and compound
// read-then-write accesses on a 2**AW x 16 single-port, read-first RAM.
// A compound access reads the old word in IDLE, then writes din to the same
// (latched) address in CMP_WR, stalling new requests for one cen cycle.
//
// Ports:
//   clk      : system clock, all state on rising edge
//   rst_n    : asynchronous active-low reset (array contents not reset)
//   cen      : clock enable, nothing changes when low
//   addr     : 16-bit pointer, only addr[AW-1:0] used (upper bits alias)
//   rd_en    : read request
//   wr_en    : write request
//   cmp_en   : compound request (read old word, then write din)
//   din      : write data
//   dout     : registered read data
//   dout_vld : high for one cen cycle after a read phase
//   busy     : high while the compound write phase is pending
// -----------------------------------------------------------------------------
module jtdsp16_ram #(
    parameter int AW = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic [15:0] addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic        cmp_en,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        dout_vld,
    output logic        busy
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_CMP_WR = 1'b1;

    logic [15:0]   r_mem [0:(2**AW)-1];
    logic [0:0]    r_state;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_dout;
    logic          r_vld;
    logic          r_busy;

    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [AW-1:0] w_raddr;
    logic          w_unused_addr;

    // Upper pointer bits are deliberately ignored: addresses alias modulo 2**AW.
    assign w_unused_addr = ^addr[15:AW];
    assign w_raddr       = addr[AW-1:0];

    // Array write port control: IDLE writes from the live pointer, CMP_WR
    // writes the address latched when the compound access started.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_raddr;
        case (r_state)
            ST_IDLE: begin
                w_we    = wr_en & ~cmp_en;
                w_waddr = w_raddr;
            end
            ST_CMP_WR: begin
                w_we    = 1'b1;
                w_waddr = r_addr;
            end
            default: begin
                w_we    = 1'b0;
                w_waddr = w_raddr;
            end
        endcase
    end

    // RAM array write; no reset on the array. Writes are suppressed while
    // rst_n is low so a reset during CMP_WR leaves the target word intact.
    always_ff @(posedge clk) begin
        if (cen && rst_n && w_we) begin
            r_mem[w_waddr] <= din;
        end
    end

    // Access FSM and registered outputs. The read samples the array before
    // the same-edge write lands, giving read-first behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= {AW{1'b0}};
            r_dout  <= 16'h0000;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
        end else if (cen) begin
            case (r_state)
                ST_IDLE: begin
                    if (cmp_en) begin
                        r_dout  <= r_mem[w_raddr];
                        r_vld   <= 1'b1;
                        r_addr  <= w_raddr;
                        r_busy  <= 1'b1;
                        r_state <= ST_CMP_WR;
                    end else if (rd_en) begin
                        r_dout  <= r_mem[w_raddr];
                        r_vld   <= 1'b1;
                    end else begin
                        r_vld   <= 1'b0;
                    end
                end
                ST_CMP_WR: begin
                    r_busy  <= 1'b0;
                    r_vld   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_vld   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dout     = r_dout;
    assign dout_vld = r_vld;
    assign busy     = r_busy;

endmodule
